// File: rtl/sram_arb_ctrl.sv
// Round-robin two-port arbiter and strobe sequencer for the async SRAM controller.
// Read data RD_CYC+1 cycles after grant; write occupies WR_CYC+2 cycles; requesters hold req until ack.
module sram_arb_ctrl #(
  parameter int AW     = 17,
  parameter int DW     = 16,
  parameter int RD_CYC = 2,
  parameter int WR_CYC = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic [1:0]    p0_be_n,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic [1:0]    p1_be_n,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          mem_we_n,
  output logic          mem_oe_n,
  output logic [1:0]    mem_be_n
);

  generate
    if (RD_CYC < 1 || WR_CYC < 1) begin : g_bad_param
      $error("sram_arb_ctrl: RD_CYC and WR_CYC must both be >= 1");
    end
  endgenerate

  localparam int MAXC = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYC - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_CYC - 1);

  typedef enum logic [2:0] {IDLE, RD, WSETUP, WPULSE, WHOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sel_q, sel_d;
  logic            rr_last_q, rr_last_d;
  logic            p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
  logic            p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
  logic [DW-1:0]   p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_din_q, mem_din_d;
  logic            mem_we_n_q, mem_we_n_d, mem_oe_n_q, mem_oe_n_d;
  logic [1:0]      mem_be_n_q, mem_be_n_d;
  logic            both_req, gnt_port;

  // Contention goes to the port that did not win the last contention.
  assign both_req = p0_req & p1_req;
  assign gnt_port = both_req ? ~rr_last_q : p1_req;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    rr_last_d   = rr_last_q;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_we_n_d  = mem_we_n_q;
    mem_oe_n_d  = mem_oe_n_q;
    mem_be_n_d  = mem_be_n_q;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          sel_d    = gnt_port;
          cnt_d    = '0;
          p0_ack_d = ~gnt_port;
          p1_ack_d = gnt_port;
          if (both_req) rr_last_d = gnt_port;
          mem_addr_d = gnt_port ? p1_addr  : p0_addr;
          mem_din_d  = gnt_port ? p1_wdata : p0_wdata;
          mem_be_n_d = gnt_port ? p1_be_n  : p0_be_n;
          if (gnt_port ? p1_we : p0_we) begin
            state_d = WSETUP;
          end else begin
            state_d    = RD;
            mem_oe_n_d = 1'b0;
          end
        end
      end
      RD: begin
        if (cnt_q == RD_LAST) begin
          state_d    = IDLE;
          mem_oe_n_d = 1'b1;
          mem_be_n_d = 2'b11;
          if (sel_q) begin
            p1_rdata_d  = mem_dout;
            p1_rvalid_d = 1'b1;
          end else begin
            p0_rdata_d  = mem_dout;
            p0_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WSETUP: begin
        state_d    = WPULSE;
        cnt_d      = '0;
        mem_we_n_d = 1'b0;
      end
      WPULSE: begin
        if (cnt_q == WR_LAST) begin
          state_d    = WHOLD;
          mem_we_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WHOLD: begin
        state_d    = IDLE;
        mem_be_n_d = 2'b11;
      end
      default: begin
        state_d    = IDLE;
        mem_we_n_d = 1'b1;
        mem_oe_n_d = 1'b1;
        mem_be_n_d = 2'b11;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      rr_last_q   <= 1'b1;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_n_q  <= 1'b1;
      mem_oe_n_q  <= 1'b1;
      mem_be_n_q  <= 2'b11;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      rr_last_q   <= rr_last_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_n_q  <= mem_we_n_d;
      mem_oe_n_q  <= mem_oe_n_d;
      mem_be_n_q  <= mem_be_n_d;
    end
  end

  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_we_n  = mem_we_n_q;
  assign mem_oe_n  = mem_oe_n_q;
  assign mem_be_n  = mem_be_n_q;

endmodule
